booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//  Parametrised sequential radix-2 Booth multiplier core with valid/ready handshakes.
//  Supports signed (two's complement) and unsigned operands, selected per operation.
//  Replaces the fixed 8-bit signed multiplier datapath. Sits between the operand
//  capture logic (switches/push-button) and the LED / 7-segment result display.
// PARAMETERS
//  WIDTH  8  operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
//  CLK100MHZ  in   1          system clock, rising edge
//  reset      in   1          asynchronous, active-high reset
//  in_valid   in   1          operands a/b/is_signed valid
//  in_ready   out  1          core idle, can accept operands
//  a          in   WIDTH      multiplicand
//  b          in   WIDTH      multiplier
//  is_signed  in   1          1: two's complement operands; 0: unsigned
//  abort      in   1          synchronous cancel of the current operation
//  out_valid  out  1          product valid
//  out_ready  in   1          consumer accepts product
//  product    out  2*WIDTH    result a*b
//  busy       out  1          high in CALC or DONE
// BEHAVIOUR
//  - Reset (async, any time, including mid-operation): state=IDLE, in_ready=1,
//    out_valid=0, busy=0, product=0, internal registers=0.
//  - Internal width W1=WIDTH+1. On accept, a and b are extended to W1 bits:
//    sign-extended if is_signed=1, zero-extended otherwise. This makes unsigned
//    operands valid Booth inputs.
//  - FSM IDLE -> CALC -> DONE -> IDLE. Registers: acc[W1], q[W1], q_1, mcand[W1], cnt.
//  - IDLE: in_ready=1. Accept on the edge where in_valid && in_ready.
//    Load acc=0, q=ext(b), q_1=0, mcand=ext(a), cnt=W1-1. Go to CALC.
//    in_valid while not IDLE is ignored; no operand is queued.
//  - CALC, one Booth step per cycle on {q[0],q_1}:
//    01 -> acc+=mcand; 10 -> acc-=mcand; 00/11 -> no op.
//    Then arithmetic right shift of {acc,q,q_1} by 1.
//    At cnt==0 the step completes and the state goes to DONE; otherwise cnt-=1.
//  - Latency: out_valid rises after the (WIDTH+1)th rising edge following the
//    accept edge. Exactly W1 steps are performed.
//  - DONE: out_valid=1; product = lower 2*WIDTH bits of {acc,q}, held stable.
//    On out_valid && out_ready, go to IDLE; in_ready=1 in the next cycle.
//    out_ready low: hold indefinitely.
//  - abort=1 in CALC or DONE: go to IDLE next edge, out_valid=0, product unchanged.
//    abort in IDLE has no effect, and abort wins over an accept in the same cycle.
//  - Arithmetic is modulo 2^W1 in acc; the truncated product is exact for all inputs,
//    including the most-negative operands.
//  - product retains its last value in IDLE until the next result is written.
// STRUCTURE
//  - booth_pkg: typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_t;
//    function clog2-based counter width helper.
//  - Sub-module booth_step (combinational, parameter W1): inputs acc, q, q_1, mcand;
//    outputs next acc, q, q_1 (add/sub plus arithmetic shift). Instantiated once;
//    the FSM and registers stay in booth_mult_seq.
// TESTING
//  - WIDTH=8, signed: a=7, b=4 -> product=16'h001C after 9 cycles; out_valid 1 cycle
//    with out_ready=1.
//  - WIDTH=8, signed: a=-128, b=-128 -> 16'h4000; a=-1, b=1 -> 16'hFFFF;
//    a=-5, b=3 -> 16'hFFF1.
//  - WIDTH=8, unsigned: a=255, b=255 -> 16'hFE01; a=0, b=200 -> 16'h0000.
//  - Backpressure: out_ready=0 for 5 cycles -> out_valid and product stay stable;
//    in_valid pulses during CALC/DONE ignored (in_ready=0).
//  - reset asserted at CALC step 4 (async, between edges) -> outputs cleared
//    immediately; next op a=3, b=3 -> 16'h0009.
//    abort during CALC -> IDLE, no out_valid.
//  - WIDTH=16 random signed/unsigned sweep (1000 ops) vs reference model, random
//    out_ready.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// Holds the controller state encoding and the step-counter sizing function.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } booth_state_t;

   // Bits needed for a down-counter that starts at n-1 and stops at 0.
   function automatic int cnt_width(input int n);
      if (n <= 2) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// followed by an arithmetic right shift of {acc, q, q_1}.
module booth_step #(
   parameter int W1 = 9
) (
   input  logic [W1-1:0] acc,
   input  logic [W1-1:0] q,
   input  logic          q_1,
   input  logic [W1-1:0] mcand,
   output logic [W1-1:0] acc_next,
   output logic [W1-1:0] q_next,
   output logic          q_1_next
);

   logic [W1-1:0] sum;

   always_comb begin
      sum = acc;
      case ({q[0], q_1})
         2'b01:   sum = acc + mcand;
         2'b10:   sum = acc - mcand;
         default: sum = acc;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < W1 - 1; gi++) begin : g_shift
         assign acc_next[gi] = sum[gi + 1];
         assign q_next[gi]   = q[gi + 1];
      end
   endgenerate

   // Sign of the sum refills the top; its LSB crosses into q.
   assign acc_next[W1-1] = sum[W1-1];
   assign q_next[W1-1]   = sum[0];
   assign q_1_next       = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation,
// with valid/ready handshakes on both sides and a synchronous abort.
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               CLK100MHZ,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int W1 = WIDTH + 1;
   localparam int CW = cnt_width(W1);
   localparam int PW = 2 * WIDTH;

   booth_state_t  state_reg, state_next;
   logic [W1-1:0] acc_reg, acc_next;
   logic [W1-1:0] q_reg, q_next;
   logic          q_1_reg, q_1_next;
   logic [W1-1:0] mcand_reg, mcand_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [PW-1:0] product_reg, product_next;

   logic [W1-1:0] step_acc;
   logic [W1-1:0] step_q;
   logic          step_q_1;

   // One extra bit lets unsigned operands behave as non-negative Booth inputs.
   function automatic logic [W1-1:0] extend(input logic [WIDTH-1:0] x, input logic sgn);
      return {sgn & x[WIDTH-1], x};
   endfunction

   booth_step #(
      .W1(W1)
   ) u_step (
      .acc      (acc_reg),
      .q        (q_reg),
      .q_1      (q_1_reg),
      .mcand    (mcand_reg),
      .acc_next (step_acc),
      .q_next   (step_q),
      .q_1_next (step_q_1)
   );

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         acc_reg     <= '0;
         q_reg       <= '0;
         q_1_reg     <= 1'b0;
         mcand_reg   <= '0;
         cnt_reg     <= '0;
         product_reg <= '0;
      end else begin
         state_reg   <= state_next;
         acc_reg     <= acc_next;
         q_reg       <= q_next;
         q_1_reg     <= q_1_next;
         mcand_reg   <= mcand_next;
         cnt_reg     <= cnt_next;
         product_reg <= product_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      acc_next     = acc_reg;
      q_next       = q_reg;
      q_1_next     = q_1_reg;
      mcand_next   = mcand_reg;
      cnt_next     = cnt_reg;
      product_next = product_reg;

      case (state_reg)
         IDLE: begin
            // abort blocks a same-cycle accept
            if (in_valid && !abort) begin
               acc_next   = '0;
               q_next     = extend(b, is_signed);
               q_1_next   = 1'b0;
               mcand_next = extend(a, is_signed);
               cnt_next   = CW'(W1 - 1);
               state_next = CALC;
            end
         end
         CALC: begin
            if (abort) begin
               state_next = IDLE;
            end else begin
               acc_next = step_acc;
               q_next   = step_q;
               q_1_next = step_q_1;
               if (cnt_reg == '0) begin
                  state_next   = DONE;
                  product_next = {step_acc[W1-3:0], step_q};
               end else begin
                  cnt_next = cnt_reg - CW'(1);
               end
            end
         end
         DONE: begin
            if (abort || out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign product   = product_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: directed 8-bit vectors with literal expectations,
// plus a 16-bit random sweep, all checked every cycle against a latency/product model.
module tb_booth_mult_seq;

   typedef struct packed {
      bit     idle;
      bit     done;
      int     left;
      longint prod;
      longint pend;
   } model_t;

   logic        clk;
   logic        reset;

   logic        iv8, ir8, s8, ab8, ov8, or8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   logic        iv16, ir16, s16, ab16, ov16, or16, busy16;
   logic [15:0] a16, b16;
   logic [31:0] p16;

   model_t m8, m16;
   int     n_checks = 0;
   int     n_fail   = 0;
   int     done16   = 0;
   bit     sweep_on = 0;

   booth_mult_seq #(.WIDTH(8)) u_dut8 (
      .CLK100MHZ (clk),
      .reset     (reset),
      .in_valid  (iv8),
      .in_ready  (ir8),
      .a         (a8),
      .b         (b8),
      .is_signed (s8),
      .abort     (ab8),
      .out_valid (ov8),
      .out_ready (or8),
      .product   (p8),
      .busy      (busy8)
   );

   booth_mult_seq #(.WIDTH(16)) u_dut16 (
      .CLK100MHZ (clk),
      .reset     (reset),
      .in_valid  (iv16),
      .in_ready  (ir16),
      .a         (a16),
      .b         (b16),
      .is_signed (s16),
      .abort     (ab16),
      .out_valid (ov16),
      .out_ready (or16),
      .product   (p16),
      .busy      (busy16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Exact product of the extended operands, truncated to 2*w bits.
   function automatic longint ref_mul(input longint av, input longint bv, input bit sg, input int w);
      longint mask, ea, eb;
      mask = (longint'(1) << w) - 1;
      ea = av & mask;
      eb = bv & mask;
      if (sg && ea[w-1]) ea = ea - (longint'(1) << w);
      if (sg && eb[w-1]) eb = eb - (longint'(1) << w);
      return (ea * eb) & ((longint'(1) << (2 * w)) - 1);
   endfunction

   function automatic model_t model_reset();
      model_t m;
      m.idle = 1'b1;
      m.done = 1'b0;
      m.left = 0;
      m.prod = 0;
      m.pend = 0;
      return m;
   endfunction

   // Result appears w+1 edges after acceptance; aborts and handshakes return to idle.
   function automatic model_t model_next(input model_t m, input int w, input bit iv, input bit ab,
                                         input bit ordy, input longint av, input longint bv, input bit sg);
      model_t n;
      n = m;
      if (m.idle) begin
         if (iv && !ab) begin
            n.idle = 1'b0;
            n.left = w + 1;
            n.pend = ref_mul(av, bv, sg, w);
         end
      end else if (ab) begin
         n.idle = 1'b1;
         n.done = 1'b0;
         n.left = 0;
      end else if (m.left > 0) begin
         n.left = m.left - 1;
         if (n.left == 0) begin
            n.done = 1'b1;
            n.prod = m.pend;
         end
      end else if (ordy) begin
         n.done = 1'b0;
         n.idle = 1'b1;
      end
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) m8 <= model_reset();
      else       m8 <= model_next(m8, 8, iv8, ab8, or8, longint'(a8), longint'(b8), s8);
   end

   always @(posedge clk or posedge reset) begin
      if (reset) m16 <= model_reset();
      else       m16 <= model_next(m16, 16, iv16, ab16, or16, longint'(a16), longint'(b16), s16);
   end

   // Per-cycle comparison of both instances against the model.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         chk("m8_in_ready",   longint'(ir8),   longint'(m8.idle));
         chk("m8_busy",       longint'(busy8), longint'(!m8.idle));
         chk("m8_out_valid",  longint'(ov8),   longint'(m8.done));
         chk("m8_product",    longint'(p8),    m8.prod);
         chk("m16_in_ready",  longint'(ir16),  longint'(m16.idle));
         chk("m16_busy",      longint'(busy16), longint'(!m16.idle));
         chk("m16_out_valid", longint'(ov16),  longint'(m16.done));
         chk("m16_product",   longint'(p16),   m16.prod);
         if (ov16 && or16) begin
            done16++;
            $display("sweep result %0d: product=%08h", done16, p16);
         end
      end
   end

   // Random backpressure for the sweep, changed just after each rising edge.
   initial forever begin
      @(posedge clk);
      #1;
      if (sweep_on) or16 = 1'($urandom_range(0, 1));
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic start8(input logic [7:0] av, input logic [7:0] bv, input bit sg);
      a8  = av;
      b8  = bv;
      s8  = sg;
      iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
   endtask

   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit sg,
                      input logic [15:0] expv, input int hold, input string nm);
      int cyc;
      or8 = (hold == 0);
      start8(av, bv, sg);
      cyc = 1;
      while (!ov8 && cyc < 40) begin
         if (hold > 0) iv8 = (cyc == 3);
         @(negedge clk);
         cyc++;
      end
      iv8 = 1'b0;
      chk({nm, "_latency"}, longint'(cyc), 10);
      chk({nm, "_product"}, longint'(p8), longint'(expv));
      $display("op %s: a=%02h b=%02h signed=%0d product=%04h edges=%0d", nm, av, bv, sg, p8, cyc - 1);
      for (int k = 0; k < hold; k++) begin
         a8  = ~av;
         iv8 = k[0];
         @(negedge clk);
         chk({nm, "_hold_valid"}, longint'(ov8), 1);
         chk({nm, "_hold_product"}, longint'(p8), longint'(expv));
         chk({nm, "_hold_in_ready"}, longint'(ir8), 0);
      end
      iv8 = 1'b0;
      or8 = 1'b1;
      @(negedge clk);
      chk({nm, "_valid_pulse"}, longint'(ov8), 0);
      chk({nm, "_back_idle"}, longint'(ir8), 1);
   endtask

   initial begin
      bit seen;
      int w;
      reset = 1'b1;
      {iv8, s8, ab8} = '0;
      or8 = 1'b1;
      a8 = '0;
      b8 = '0;
      {iv16, s16, ab16} = '0;
      or16 = 1'b1;
      a16 = '0;
      b16 = '0;

      #12;
      chk("reset_in_ready",  longint'(ir8),   1);
      chk("reset_out_valid", longint'(ov8),   0);
      chk("reset_busy",      longint'(busy8), 0);
      chk("reset_product",   longint'(p8),    0);
      #1 reset = 1'b0;
      @(negedge clk);

      op8(8'd7,   8'd4,   1'b1, 16'h001C, 0, "s_7x4");
      op8(8'h80,  8'h80,  1'b1, 16'h4000, 0, "s_m128xm128");
      op8(8'hFF,  8'h01,  1'b1, 16'hFFFF, 0, "s_m1x1");
      op8(8'hFB,  8'h03,  1'b1, 16'hFFF1, 5, "s_m5x3_bp");
      op8(8'd0,   8'd200, 1'b0, 16'h0000, 0, "u_0x200");
      op8(8'd255, 8'd255, 1'b0, 16'hFE01, 0, "u_255x255");

      // Asynchronous reset between edges after the fourth Booth step.
      start8(8'd100, 8'hF9, 1'b1);
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_in_ready",  longint'(ir8),   1);
      chk("async_rst_out_valid", longint'(ov8),   0);
      chk("async_rst_busy",      longint'(busy8), 0);
      chk("async_rst_product",   longint'(p8),    0);
      #1 reset = 1'b0;
      @(negedge clk);
      op8(8'd3, 8'd3, 1'b1, 16'h0009, 0, "s_3x3_after_reset");

      // Abort during CALC: back to idle, product untouched, no result.
      start8(8'd9, 8'd9, 1'b0);
      repeat (3) @(negedge clk);
      ab8 = 1'b1;
      @(negedge clk);
      ab8 = 1'b0;
      chk("abort_calc_in_ready", longint'(ir8),   1);
      chk("abort_calc_busy",     longint'(busy8), 0);
      chk("abort_calc_product",  longint'(p8),    16'h0009);
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (ov8) seen = 1'b1;
      end
      chk("abort_calc_no_valid", longint'(seen), 0);
      $display("op abort_calc: cancelled 9x9, product=%04h", p8);

      // Abort beats a same-cycle accept in IDLE.
      ab8 = 1'b1;
      a8  = 8'd2;
      b8  = 8'd2;
      iv8 = 1'b1;
      @(negedge clk);
      ab8 = 1'b0;
      iv8 = 1'b0;
      chk("abort_idle_in_ready", longint'(ir8),   1);
      chk("abort_idle_busy",     longint'(busy8), 0);
      $display("op abort_idle: accept blocked, in_ready=%0d", ir8);

      // Abort while holding a result drops out_valid but keeps the product.
      or8 = 1'b0;
      start8(8'd2, 8'd5, 1'b0);
      w = 0;
      while (!ov8 && w < 40) begin
         @(negedge clk);
         w++;
      end
      chk("abort_done_reached", longint'(ov8), 1);
      ab8 = 1'b1;
      @(negedge clk);
      ab8 = 1'b0;
      or8 = 1'b1;
      chk("abort_done_out_valid", longint'(ov8), 0);
      chk("abort_done_product",   longint'(p8),  16'h000A);
      chk("abort_done_in_ready",  longint'(ir8), 1);
      $display("op abort_done: product held at %04h", p8);

      // 16-bit random sweep under random backpressure.
      sweep_on = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         w = 0;
         while (!ir16 && w < 100) begin
            @(negedge clk);
            w++;
         end
         if (w >= 100) chk("sweep_ready_timeout", longint'(ir16), 1);
         a16  = 16'($urandom);
         b16  = 16'($urandom);
         s16  = 1'($urandom_range(0, 1));
         iv16 = 1'b1;
         @(negedge clk);
         iv16 = 1'b0;
      end
      w = 0;
      while (!ir16 && w < 200) begin
         @(negedge clk);
         w++;
      end
      sweep_on = 1'b0;
      or16 = 1'b1;
      @(negedge clk);
      chk("sweep_results", longint'(done16), 1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
